// File: rtl/exu_wbu_reg_pkg.sv
// Shared widths and the bundled EXU->WBU payload type for the exu_wbu_reg slice.
package exu_wbu_reg_pkg;

   localparam int XLEN          = 64;
   localparam int REG_IDX_WIDTH = 5;

   typedef struct packed {
      logic [XLEN-1:0]          pc;
      logic [XLEN-1:0]          dst_data;
      logic [REG_IDX_WIDTH-1:0] rd;
      logic                     rd_wen;
   } wbu_payload_t;

   // 64 + 64 + 5 + 1 = 134 bits.
   localparam int WBU_PAYLOAD_WIDTH = $bits(wbu_payload_t);

   // Writes to x0 are architecturally discarded, so never carry them forward.
   function automatic logic effective_rd_wen(input logic wen, input logic [REG_IDX_WIDTH-1:0] rd);
      return wen && (rd != '0);
   endfunction

endpackage

// File: rtl/exu_wbu_fifo2.sv
// Generic in-order storage for the EXU->WBU boundary: a 2-entry skid buffer when
// EXU_WBU_SKID_EN is defined, otherwise a single-entry register. All outputs are flops.
module exu_wbu_fifo2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             not_empty,
   output logic             not_full
);

`ifdef EXU_WBU_SKID_EN

   logic [1:0]       count_q;
   logic [1:0]       count_nxt;
   logic             not_empty_q;
   logic             not_full_q;
   logic [WIDTH-1:0] entry0_q;
   logic [WIDTH-1:0] entry1_q;

   always_comb begin
      // NOTE: assign a default before any branch so the block never infers a latch.
      count_nxt = count_q;
      if (flush) begin
         count_nxt = 2'd0;
      end else if (push && !pop) begin
         count_nxt = count_q + 2'd1;
      end else if (pop && !push) begin
         count_nxt = count_q - 2'd1;
      end
   end

   // entry1_q is kept at zero whenever it is unoccupied, so shifting it into the
   // head on the last pop also clears the head payload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset too, so the head reads all-zero (including rd_wen) when empty.
         count_q     <= 2'd0;
         not_empty_q <= 1'b0;
         not_full_q  <= 1'b1;
         entry0_q    <= '0;
         entry1_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         count_q     <= count_nxt;
         not_empty_q <= (count_nxt != 2'd0);
         not_full_q  <= (count_nxt != 2'd2);
         if (flush) begin
            entry0_q <= '0;
            entry1_q <= '0;
         end else begin
            case ({push, pop})
               2'b10: begin
                  if (count_q == 2'd0) entry0_q <= din;
                  else                 entry1_q <= din;
               end
               2'b01: begin
                  entry0_q <= entry1_q;
                  entry1_q <= '0;
               end
               2'b11: begin
                  if (count_q == 2'd1) begin
                     entry0_q <= din;
                  end else begin
                     entry0_q <= entry1_q;
                     entry1_q <= din;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign head      = entry0_q;
   assign not_empty = not_empty_q;
   assign not_full  = not_full_q;

`else

   logic             valid_q;
   logic [WIDTH-1:0] entry0_q;

   // A push while full is only ever issued alongside a pop, so push simply overwrites.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         entry0_q <= '0;
      end else if (flush) begin
         valid_q  <= 1'b0;
         entry0_q <= '0;
      end else if (push) begin
         valid_q  <= 1'b1;
         entry0_q <= din;
      end else if (pop) begin
         valid_q  <= 1'b0;
         entry0_q <= '0;
      end
   end

   assign head      = entry0_q;
   assign not_empty = valid_q;
   assign not_full  = !valid_q;

`endif

endmodule

// File: rtl/exu_wbu_reg.sv
// EXU->WBU pipeline boundary: result select, x0 write suppression, in-order storage
// and a muldiv retirement counter. Define EXU_WBU_SKID_EN for the 2-entry skid build.
module exu_wbu_reg
   import exu_wbu_reg_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     exu_valid,
   output logic                     exu_ready,
   input  logic [XLEN-1:0]          exu_pc,
   input  logic [XLEN-1:0]          exu_alu_dst_data,
   input  logic                     muldiv_en,
   input  logic [XLEN-1:0]          muldiv_wbu_dst_data,
   input  logic [REG_IDX_WIDTH-1:0] exu_rd,
   input  logic                     exu_rd_wen,
   input  logic                     flush,
   output logic                     wbu_valid,
   input  logic                     wbu_ready,
   output logic [XLEN-1:0]          wbu_pc,
   output logic [XLEN-1:0]          wbu_dst_data,
   output logic [REG_IDX_WIDTH-1:0] wbu_rd,
   output logic                     wbu_rd_wen,
   output logic [XLEN-1:0]          muldiv_cnt
);

   wbu_payload_t in_payload;
   wbu_payload_t head_payload;
   logic         fifo_not_empty;
   logic         fifo_not_full;
   logic         push;
   logic         pop;
   logic [XLEN-1:0] muldiv_cnt_q;

   assign in_payload.pc       = exu_pc;
   assign in_payload.dst_data = muldiv_en ? muldiv_wbu_dst_data : exu_alu_dst_data;
   assign in_payload.rd       = exu_rd;
   assign in_payload.rd_wen   = effective_rd_wen(exu_rd_wen, exu_rd);

   // Flush wins over both handshakes: nothing enters or leaves in a flush cycle.
   assign push = exu_valid && exu_ready && !flush;
   assign pop  = wbu_valid && wbu_ready && !flush;

`ifdef EXU_WBU_SKID_EN
   assign exu_ready = fifo_not_full;
`else
   assign exu_ready = fifo_not_full || wbu_ready;
`endif

   exu_wbu_fifo2 #(
      .WIDTH (WBU_PAYLOAD_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .din       (in_payload),
      .head      (head_payload),
      .not_empty (fifo_not_empty),
      .not_full  (fifo_not_full)
   );

   assign wbu_valid    = fifo_not_empty;
   assign wbu_pc       = head_payload.pc;
   assign wbu_dst_data = head_payload.dst_data;
   assign wbu_rd       = head_payload.rd;
   assign wbu_rd_wen   = head_payload.rd_wen;

   // Counts accepted muldiv beats; flush does not rewind it, and it wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         muldiv_cnt_q <= '0;
      end else if (push && muldiv_en) begin
         muldiv_cnt_q <= muldiv_cnt_q + 64'd1;
      end
   end

   assign muldiv_cnt = muldiv_cnt_q;

endmodule

// File: tb/tb_exu_wbu_reg.sv
// Self-checking bench for exu_wbu_reg: queue-based reference model, directed cases
// with literal expectations, then randomized traffic. Works in either build.
module tb_exu_wbu_reg;
   import exu_wbu_reg_pkg::*;

`ifdef EXU_WBU_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid;
   logic        exu_ready;
   logic [63:0] exu_pc;
   logic [63:0] exu_alu_dst_data;
   logic        muldiv_en;
   logic [63:0] muldiv_wbu_dst_data;
   logic [4:0]  exu_rd;
   logic        exu_rd_wen;
   logic        flush;
   logic        wbu_valid;
   logic        wbu_ready;
   logic [63:0] wbu_pc;
   logic [63:0] wbu_dst_data;
   logic [4:0]  wbu_rd;
   logic        wbu_rd_wen;
   logic [63:0] muldiv_cnt;

   always #5 clk = ~clk;

   exu_wbu_reg dut (
      .clk                 (clk),
      .rst                 (rst),
      .exu_valid           (exu_valid),
      .exu_ready           (exu_ready),
      .exu_pc              (exu_pc),
      .exu_alu_dst_data    (exu_alu_dst_data),
      .muldiv_en           (muldiv_en),
      .muldiv_wbu_dst_data (muldiv_wbu_dst_data),
      .exu_rd              (exu_rd),
      .exu_rd_wen          (exu_rd_wen),
      .flush               (flush),
      .wbu_valid           (wbu_valid),
      .wbu_ready           (wbu_ready),
      .wbu_pc              (wbu_pc),
      .wbu_dst_data        (wbu_dst_data),
      .wbu_rd              (wbu_rd),
      .wbu_rd_wen          (wbu_rd_wen),
      .muldiv_cnt          (muldiv_cnt)
   );

   typedef struct {
      logic [63:0] pc;
      logic [63:0] data;
      logic [4:0]  rd;
      logic        wen;
   } beat_t;

   beat_t       model_q[$];
   logic [63:0] model_cnt;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Readiness as the backpressure rules define it, from model occupancy only.
   function automatic logic model_ready();
      if (SKID) return model_q.size() != 2;
      return (model_q.size() == 0) || wbu_ready;
   endfunction

   task automatic compare_outputs();
      check("exu_ready", 64'(exu_ready), 64'(model_ready()));
      check("wbu_valid", 64'(wbu_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         check("wbu_pc", wbu_pc, model_q[0].pc);
         check("wbu_dst_data", wbu_dst_data, model_q[0].data);
         check("wbu_rd", 64'(wbu_rd), 64'(model_q[0].rd));
         check("wbu_rd_wen", 64'(wbu_rd_wen), 64'(model_q[0].wen));
      end else begin
         check("wbu_rd_wen_idle", 64'(wbu_rd_wen), 64'd0);
      end
      check("muldiv_cnt", muldiv_cnt, model_cnt);
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle();
      logic  push_m;
      logic  pop_m;
      logic  flush_m;
      logic  md_m;
      beat_t b;
      #1;
      compare_outputs();
      flush_m = flush;
      md_m    = muldiv_en;
      push_m  = exu_valid && model_ready() && !flush;
      pop_m   = (model_q.size() != 0) && wbu_ready && !flush;
      b.pc    = exu_pc;
      b.data  = muldiv_en ? muldiv_wbu_dst_data : exu_alu_dst_data;
      b.rd    = exu_rd;
      b.wen   = exu_rd_wen && (exu_rd != 5'd0);
      @(posedge clk);
      if (flush_m) begin
         model_q.delete();
      end else begin
         if (pop_m) void'(model_q.pop_front());
         if (push_m) model_q.push_back(b);
      end
      if (push_m && md_m) model_cnt = model_cnt + 64'd1;
      @(negedge clk);
   endtask

   task automatic set_beat(input logic v, input logic [63:0] pc, input logic [63:0] alu,
                           input logic [63:0] md, input logic mden, input logic [4:0] rd,
                           input logic wen);
      exu_valid           = v;
      exu_pc              = pc;
      exu_alu_dst_data    = alu;
      muldiv_wbu_dst_data = md;
      muldiv_en           = mden;
      exu_rd              = rd;
      exu_rd_wen          = wen;
   endtask

   task automatic idle();
      set_beat(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      wbu_ready = 1'b0;
      model_cnt = 64'd0;
      idle();
      #2;
      check("reset_wbu_valid", 64'(wbu_valid), 64'd0);
      check("reset_wbu_pc", wbu_pc, 64'd0);
      check("reset_wbu_dst_data", wbu_dst_data, 64'd0);
      check("reset_wbu_rd", 64'(wbu_rd), 64'd0);
      check("reset_wbu_rd_wen", 64'(wbu_rd_wen), 64'd0);
      check("reset_muldiv_cnt", muldiv_cnt, 64'd0);
      check("reset_exu_ready", 64'(exu_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Plain ALU beat.
      set_beat(1'b1, 64'h100, 64'h11, 64'h0, 1'b0, 5'd3, 1'b1);
      cycle();
      check("alu_valid", 64'(wbu_valid), 64'd1);
      check("alu_data", wbu_dst_data, 64'h11);
      check("alu_rd", 64'(wbu_rd), 64'd3);
      check("alu_wen", 64'(wbu_rd_wen), 64'd1);
      check("alu_cnt", muldiv_cnt, 64'd0);
      idle(); wbu_ready = 1'b1;
      cycle();
      check("alu_drained", 64'(wbu_valid), 64'd0);

      // Muldiv beat selects the muldiv result.
      wbu_ready = 1'b0;
      set_beat(1'b1, 64'h104, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 5'd7, 1'b1);
      cycle();
      check("md_data", wbu_dst_data, 64'hFFFF_FFFF_FFFF_FFFE);
      check("md_cnt", muldiv_cnt, 64'd1);
      idle(); wbu_ready = 1'b1;
      cycle();

      // x0 destination write is suppressed.
      wbu_ready = 1'b0;
      set_beat(1'b1, 64'h108, 64'h22, 64'h0, 1'b0, 5'd0, 1'b1);
      cycle();
      check("x0_valid", 64'(wbu_valid), 64'd1);
      check("x0_wen", 64'(wbu_rd_wen), 64'd0);
      idle(); wbu_ready = 1'b1;
      cycle();

      // Backpressure and ordering.
      wbu_ready = 1'b0;
      set_beat(1'b1, 64'hA00, 64'hA, 64'h0, 1'b0, 5'd1, 1'b1);
      cycle();
      if (SKID) begin
         set_beat(1'b1, 64'hB00, 64'hB, 64'h0, 1'b0, 5'd2, 1'b1);
         cycle();
         check("skid_full_ready", 64'(exu_ready), 64'd0);
         set_beat(1'b1, 64'hC00, 64'hC, 64'h0, 1'b0, 5'd4, 1'b1);
         cycle();
         check("skid_head_a", wbu_pc, 64'hA00);
         wbu_ready = 1'b1;
         cycle();
         check("skid_head_b", wbu_pc, 64'hB00);
         check("skid_ready_back", 64'(exu_ready), 64'd1);
         cycle();
         check("skid_head_c", wbu_pc, 64'hC00);
         check("skid_c_valid", 64'(wbu_valid), 64'd1);
      end else begin
         set_beat(1'b1, 64'hB00, 64'hB, 64'h0, 1'b0, 5'd2, 1'b1);
         #1;
         check("single_full_ready", 64'(exu_ready), 64'd0);
         check("single_head_a", wbu_pc, 64'hA00);
         wbu_ready = 1'b1;
         cycle();
         check("single_head_b", wbu_pc, 64'hB00);
      end
      idle(); wbu_ready = 1'b1;
      cycle();
      check("order_drained", 64'(wbu_valid), 64'd0);

      // Flush with storage full and a muldiv beat offered.
      wbu_ready = 1'b0;
      for (int k = 0; k < (SKID ? 2 : 1); k++) begin
         set_beat(1'b1, 64'hD00 + 64'(k), 64'hD, 64'h0, 1'b0, 5'd5, 1'b1);
         cycle();
      end
      set_beat(1'b1, 64'hF00, 64'h0, 64'h99, 1'b1, 5'd9, 1'b1);
      flush = 1'b1; wbu_ready = 1'b1;
      cycle();
      flush = 1'b0; idle();
      check("flush_valid", 64'(wbu_valid), 64'd0);
      check("flush_cnt", muldiv_cnt, 64'd1);
      cycle();
      check("flush_stays_empty", 64'(wbu_valid), 64'd0);

      // Asynchronous reset between edges while holding a beat.
      wbu_ready = 1'b0;
      set_beat(1'b1, 64'hE00, 64'h1, 64'h2, 1'b1, 5'd6, 1'b1);
      cycle();
      check("pre_rst_cnt", muldiv_cnt, 64'd2);
      idle();
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(wbu_valid), 64'd0);
      check("arst_cnt", muldiv_cnt, 64'd0);
      check("arst_ready", 64'(exu_ready), 64'd1);
      model_q.delete();
      model_cnt = 64'd0;
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic with alternating drain pressure.
      for (int i = 0; i < 4000; i++) begin
         set_beat($urandom_range(0, 3) != 0,
                  {$urandom, $urandom},
                  {$urandom, $urandom},
                  {$urandom, $urandom},
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom_range(0, 1)));
         wbu_ready = ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         cycle();
      end
      flush = 1'b0;
      idle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
